// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input, then derives duty
// with an R-step restoring divider once per captured period.
//
// state | meaning
// IDLE  | disabled; counters and divider cleared, outputs hold
// ARM   | counting timeout, waiting for the first rise (partial period discarded)
// MEAS  | counting period/high time, next rise captures a measurement
// DIV   | dividing high<<R by period, one quotient bit per cycle
module pwm_capture #(
    parameter int R        = 8,
    parameter int CNT_BITS = 16
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic                pwm_in,
    input  logic                enable,
    input  logic                clr_flags,
    output logic [CNT_BITS-1:0] period_count,
    output logic [CNT_BITS-1:0] high_count,
    output logic [R-1:0]        duty,
    output logic                meas_valid,
    output logic                no_signal,
    output logic                overrun
);

    localparam int CW = (R > 1) ? $clog2(R) : 1;
    localparam logic [CW-1:0]       DIV_LAST = CW'(R - 1);
    localparam logic [CW-1:0]       DIV_ONE  = CW'(1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS, S_DIV} state_t;

    state_t              state;
    logic                sync_ff1, sync_ff2, sync_prev;
    logic                rise;
    logic [CNT_BITS-1:0] pcnt, hcnt, sync_inc;
    logic [CNT_BITS-1:0] div_rem, div_den, cap_high;
    logic [R-2:0]        div_q;
    logic [CW-1:0]       div_cnt;
    logic [CNT_BITS:0]   rem_sh;
    logic [CNT_BITS-1:0] rem_next;
    logic [R-1:0]        q_next;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff1  <= 1'b0;
            sync_ff2  <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_ff1  <= pwm_in;
            sync_ff2  <= sync_ff1;
            sync_prev <= sync_ff2;
        end
    end

    assign rise     = sync_ff2 & ~sync_prev;
    assign sync_inc = {{(CNT_BITS-1){1'b0}}, sync_ff2};

    // Remainder stays below the divisor, so one extra bit covers the shift.
    always_comb begin
        rem_sh = {div_rem, 1'b0};
        if (rem_sh >= {1'b0, div_den}) begin
            rem_next = rem_sh[CNT_BITS-1:0] - div_den;
            q_next   = {div_q, 1'b1};
        end else begin
            rem_next = rem_sh[CNT_BITS-1:0];
            q_next   = {div_q, 1'b0};
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            pcnt         <= '0;
            hcnt         <= '0;
            div_rem      <= '0;
            div_den      <= '0;
            div_q        <= '0;
            div_cnt      <= '0;
            cap_high     <= '0;
            period_count <= '0;
            high_count   <= '0;
            duty         <= '0;
            meas_valid   <= 1'b0;
            no_signal    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (clr_flags)
                overrun <= 1'b0;

            if (!enable) begin
                state     <= S_IDLE;
                pcnt      <= '0;
                hcnt      <= '0;
                div_rem   <= '0;
                div_den   <= '0;
                div_q     <= '0;
                div_cnt   <= '0;
                cap_high  <= '0;
                no_signal <= 1'b0;
            end else if (state == S_IDLE) begin
                state <= S_ARM;
                pcnt  <= '0;
                hcnt  <= '0;
            end else if (pcnt == CNT_MAX) begin
                // Saturated period counter: the input has stopped toggling.
                state     <= S_ARM;
                no_signal <= 1'b1;
                pcnt      <= '0;
                hcnt      <= '0;
                div_rem   <= '0;
                div_den   <= '0;
                div_q     <= '0;
                div_cnt   <= '0;
            end else begin
                if (rise) begin
                    pcnt      <= '0;
                    hcnt      <= CNT_ONE;
                    no_signal <= 1'b0;
                end else begin
                    pcnt <= pcnt + CNT_ONE;
                    hcnt <= hcnt + sync_inc;
                end

                case (state)
                    S_ARM: begin
                        if (rise)
                            state <= S_MEAS;
                    end
                    S_MEAS: begin
                        if (rise) begin
                            div_rem  <= hcnt;
                            div_den  <= pcnt + CNT_ONE;
                            cap_high <= hcnt;
                            div_q    <= '0;
                            div_cnt  <= DIV_LAST;
                            state    <= S_DIV;
                        end
                    end
                    S_DIV: begin
                        if (rise)
                            overrun <= 1'b1;
                        div_rem <= rem_next;
                        div_q   <= q_next[R-2:0];
                        if (div_cnt == '0) begin
                            period_count <= div_den;
                            high_count   <= cap_high;
                            duty         <= q_next;
                            meas_valid   <= 1'b1;
                            state        <= S_MEAS;
                        end else begin
                            div_cnt <= div_cnt - DIV_ONE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: table-driven steady patterns, directed
// corner sequences, and random periods checked against a period-level model.
module tb_pwm_capture;
    localparam int R        = 8;
    localparam int CNT_BITS = 16;

    logic                clk_in = 1'b0;
    logic                rst_n, pwm_in, enable, clr_flags;
    logic [CNT_BITS-1:0] period_count, high_count;
    logic [R-1:0]        duty;
    logic                meas_valid, no_signal, overrun;

    pwm_capture #(.R(R), .CNT_BITS(CNT_BITS)) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .pwm_in       (pwm_in),
        .enable       (enable),
        .clr_flags    (clr_flags),
        .period_count (period_count),
        .high_count   (high_count),
        .duty         (duty),
        .meas_valid   (meas_valid),
        .no_signal    (no_signal),
        .overrun      (overrun)
    );

    always #5 clk_in = ~clk_in;

    typedef struct { int p; int h; int e_duty; } row_t;
    typedef struct { int period; int high; int duty; } meas_t;

    int    n_checks = 0, n_fail = 0;
    int    cyc = 0, mv_count = 0, mv_t_last = 0, mv_t_prev = 0;
    int    mv0, k, rp, rh;
    bit    mon_en = 1'b0;
    meas_t exp_q[$];
    meas_t mon_e;
    row_t  rows[7];

    bit model_armed, model_ovr;
    int model_t, model_last_div, model_prev_p, model_prev_h;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        model_armed    = 1'b0;
        model_ovr      = 1'b0;
        model_t        = 0;
        model_last_div = -1000;
        exp_q.delete();
    endtask

    // A rise starts a division unless it lands within R cycles of the last accepted one.
    task automatic model_rise(input int p, input int h);
        meas_t m;
        if (!model_armed) begin
            model_armed = 1'b1;
        end else if (model_t - model_last_div <= R) begin
            model_ovr = 1'b1;
        end else begin
            m.period = model_prev_p;
            m.high   = model_prev_h;
            m.duty   = (model_prev_h * (1 << R)) / model_prev_p;
            exp_q.push_back(m);
            model_last_div = model_t;
        end
        model_prev_p = p;
        model_prev_h = h;
        model_t += p;
    endtask

    task automatic pulse(input int p, input int h);
        if (mon_en) model_rise(p, h);
        pwm_in = 1'b1;
        repeat (h) @(negedge clk_in);
        pwm_in = 1'b0;
        repeat (p - h) @(negedge clk_in);
    endtask

    task automatic restart();
        enable = 1'b0;
        repeat (3) @(negedge clk_in);
        enable = 1'b1;
        repeat (3) @(negedge clk_in);
    endtask

    always @(posedge clk_in) cyc++;

    always @(negedge clk_in) begin
        if (meas_valid) begin
            mv_count++;
            mv_t_prev = mv_t_last;
            mv_t_last = cyc;
            if (mon_en) begin
                check("valid_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("mon_period", period_count, mon_e.period);
                    check("mon_high", high_count, mon_e.high);
                    check("mon_duty", duty, mon_e.duty);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; pwm_in = 1'b0; enable = 1'b0; clr_flags = 1'b0;
        rows[0] = '{100, 25, 64};
        rows[1] = '{256, 255, 255};
        rows[2] = '{10, 5, 128};
        rows[3] = '{10, 9, 230};
        rows[4] = '{37, 1, 6};
        rows[5] = '{200, 199, 254};
        rows[6] = '{13, 7, 137};

        repeat (3) @(negedge clk_in);
        check("reset_period", period_count, 0);
        check("reset_high", high_count, 0);
        check("reset_duty", duty, 0);
        check("reset_flags", {meas_valid, no_signal, overrun}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_in);

        for (int i = 0; i < 7; i++) begin
            restart();
            mv0 = mv_count;
            repeat (3) pulse(rows[i].p, rows[i].h);
            repeat (R + 6) @(negedge clk_in);
            check($sformatf("row%0d_period", i), period_count, rows[i].p);
            check($sformatf("row%0d_high", i), high_count, rows[i].h);
            check($sformatf("row%0d_duty", i), duty, rows[i].e_duty);
            check($sformatf("row%0d_valids", i), mv_count - mv0, 2);
            check($sformatf("row%0d_interval", i), mv_t_last - mv_t_prev, rows[i].p);
            check($sformatf("row%0d_overrun", i), overrun, 0);
        end

        // Raw edge -> 2 sync cycles -> detect -> R+1 cycles to meas_valid.
        restart();
        pulse(20, 10);
        pwm_in = 1'b1;
        k = 0;
        while (meas_valid !== 1'b1 && k < 40) begin
            @(negedge clk_in);
            k++;
            if (k == 10) pwm_in = 1'b0;
        end
        check("valid_latency", k, R + 3);
        repeat (20) @(negedge clk_in);

        restart();
        model_reset();
        mon_en = 1'b1;
        for (int i = 0; i < 25; i++) begin
            rp = int'($urandom_range(90, 12));
            rh = int'($urandom_range(rp - 1, 1));
            pulse(rp, rh);
        end
        pulse(20, 10);
        repeat (R + 6) @(negedge clk_in);
        mon_en = 1'b0;
        check("rand_drained", exp_q.size(), 0);
        check("rand_overrun", overrun, model_ovr);

        restart();
        model_reset();
        mon_en = 1'b1;
        repeat (12) pulse(3, 1);
        pulse(40, 20);
        pulse(40, 20);
        mon_en = 1'b0;
        check("ovr_drained", exp_q.size(), 0);
        check("ovr_set", overrun, 1);
        clr_flags = 1'b1;
        @(negedge clk_in);
        clr_flags = 1'b0;
        @(negedge clk_in);
        check("ovr_cleared", overrun, 0);

        restart();
        pulse(20, 10);
        pulse(20, 10);
        mv0 = mv_count;
        pwm_in = 1'b1;
        k = 0;
        while (no_signal !== 1'b1 && k < 70000) begin
            @(negedge clk_in);
            k++;
        end
        check("timeout_latency", k, 65539);
        check("timeout_valids", mv_count - mv0, 1);
        pwm_in = 1'b0;
        repeat (5) @(negedge clk_in);
        mv0 = mv_count;
        pulse(10, 5);
        check("nosig_cleared", no_signal, 0);
        pulse(10, 5);
        pulse(10, 5);
        repeat (R + 6) @(negedge clk_in);
        check("resume_period", period_count, 10);
        check("resume_duty", duty, 128);
        check("resume_valids", mv_count - mv0, 2);

        restart();
        pulse(30, 10);
        pulse(30, 10);
        mv0 = mv_count;
        pwm_in = 1'b1;
        repeat (5) @(negedge clk_in);
        enable = 1'b0;
        repeat (5) @(negedge clk_in);
        pwm_in = 1'b0;
        repeat (20) @(negedge clk_in);
        check("dis_valids", mv_count - mv0, 0);
        check("dis_hold_period", period_count, 30);
        check("dis_hold_high", high_count, 10);
        check("dis_hold_duty", duty, 85);
        enable = 1'b1;
        repeat (3) @(negedge clk_in);
        mv0 = mv_count;
        pulse(40, 20);
        check("reen_first_rise", mv_count - mv0, 0);
        pulse(40, 20);
        check("reen_valids", mv_count - mv0, 1);
        check("reen_duty", duty, 128);
        check("reen_period", period_count, 40);

        restart();
        pulse(50, 20);
        pulse(50, 20);
        check("pre_rst_duty", duty, 102);
        pwm_in = 1'b1;
        repeat (4) @(negedge clk_in);
        rst_n = 1'b0;
        #1;
        check("rst_period", period_count, 0);
        check("rst_high", high_count, 0);
        check("rst_duty", duty, 0);
        check("rst_flags", {meas_valid, no_signal, overrun}, 0);
        repeat (3) @(negedge clk_in);
        pwm_in = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk_in);
        mv0 = mv_count;
        repeat (3) pulse(50, 20);
        repeat (R + 6) @(negedge clk_in);
        check("post_rst_valids", mv_count - mv0, 2);
        check("post_rst_period", period_count, 50);
        check("post_rst_high", high_count, 20);
        check("post_rst_duty", duty, 102);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
